// File: rtl/e203_disp_pkg.sv
// e203_disp_pkg
// Shared definitions for the N-channel EXU dispatch stage:
//   - functional-unit channel indexes (bit positions in the one-hot channel vectors)
//   - default long-pipe channel mask (only the LSU is long-pipe)
//   - dispatch FSM state encoding
package e203_disp_pkg;

    localparam int CH_ALU    = 0;
    localparam int CH_LSU    = 1;
    localparam int CH_MULDIV = 2;

    localparam logic [2:0] LONGP_MASK_DEF = 3'b010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/e203_disp_scoreboard.sv
// e203_disp_scoreboard
// Tracks the destination registers of long-pipe instructions that have issued
// but have not yet written back.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   rs1en/rs1idx, rs2en/rs2idx, rdwen/rdidx
//                        operands of the held instruction; dep flags RAW/WAW hazards
//   alloc                a long-pipe instruction issues this cycle (uses rdwen/rdidx)
//   wbck_valid/rdwen/rdidx
//                        oldest long-pipe entry retires
//   lp_full              outstanding count has reached LP_DEPTH
//   lp_empty             nothing outstanding
//   itag                 tag handed to the next allocated entry
module e203_disp_scoreboard #(
    parameter int RFIDX_W  = 5,
    parameter int LP_DEPTH = 4,
    parameter int ITAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rs1en,
    input  logic [RFIDX_W-1:0] rs1idx,
    input  logic               rs2en,
    input  logic [RFIDX_W-1:0] rs2idx,
    input  logic               rdwen,
    input  logic [RFIDX_W-1:0] rdidx,
    output logic               dep,
    input  logic               alloc,
    input  logic               wbck_valid,
    input  logic               wbck_rdwen,
    input  logic [RFIDX_W-1:0] wbck_rdidx,
    output logic               lp_full,
    output logic               lp_empty,
    output logic [ITAG_W-1:0]  itag
);

    localparam int NREG  = 1 << RFIDX_W;
    localparam int CNT_W = ITAG_W + 1;

    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_set;
    logic [NREG-1:0]   sb_clr;
    logic [CNT_W-1:0]  cnt_q;
    logic [ITAG_W-1:0] itag_q;
    logic              dec;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        // x0 is hardwired, so it never becomes busy.
        if (alloc && rdwen && (rdidx != '0)) sb_set[rdidx] = 1'b1;
        if (wbck_valid && wbck_rdwen)        sb_clr[wbck_rdidx] = 1'b1;
    end

    // A writeback at count 0 has nothing to retire and is ignored.
    assign dec = wbck_valid && (cnt_q != '0);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q   <= '0;
            cnt_q  <= '0;
            itag_q <= '0;
        end else begin
            sb_q <= (sb_q & ~sb_clr) | sb_set;
            if (alloc && !dec)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!alloc && dec) cnt_q <= cnt_q - CNT_W'(1);
            if (alloc) itag_q <= itag_q + ITAG_W'(1);
        end
    end

    // Lookups use registered state only: a writeback clears its bit for the
    // following cycle, not the current one.
    assign dep      = (rs1en && sb_q[rs1idx]) || (rs2en && sb_q[rs2idx]) || (rdwen && sb_q[rdidx]);
    assign lp_full  = (cnt_q >= CNT_W'(LP_DEPTH));
    assign lp_empty = (cnt_q == '0);
    assign itag     = itag_q;

endmodule

// File: rtl/e203_exu_disp_nch.sv
// e203_exu_disp_nch
// N-channel dispatch stage: holds one decoded instruction and issues it to the
// one-hot selected functional-unit channel once it is free of register hazards,
// fence ordering and long-pipe capacity limits. A drain FSM sequences WFI halt.
// Ports:
//   disp_i_*      upstream instruction and valid/ready handshake
//   disp_o_*      per-channel valid/ready plus registered operands, dest and itag
//   lp_wbck_*     long-pipe writeback (retires the oldest outstanding entry)
//   wfi_halt_*    WFI halt request/acknowledge
//   lp_empty      no long-pipe instruction outstanding
//   stall_cnt     saturating count of cycles a held instruction waited on a hazard
module e203_exu_disp_nch
    import e203_disp_pkg::*;
#(
    parameter int             NCH        = 3,
    parameter int             XLEN       = 32,
    parameter int             RFIDX_W    = 5,
    parameter int             LP_DEPTH   = 4,
    parameter int             ITAG_W     = 2,
    parameter logic [NCH-1:0] LONGP_MASK = NCH'(LONGP_MASK_DEF),
    parameter int             STALLCNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_i_valid,
    output logic                  disp_i_ready,
    input  logic [NCH-1:0]        disp_i_ch,
    input  logic                  disp_i_rs1en,
    input  logic                  disp_i_rs2en,
    input  logic                  disp_i_rdwen,
    input  logic [RFIDX_W-1:0]    disp_i_rs1idx,
    input  logic [RFIDX_W-1:0]    disp_i_rs2idx,
    input  logic [RFIDX_W-1:0]    disp_i_rdidx,
    input  logic [XLEN-1:0]       disp_i_rs1,
    input  logic [XLEN-1:0]       disp_i_rs2,
    input  logic                  disp_i_fence,
    output logic [NCH-1:0]        disp_o_valid,
    input  logic [NCH-1:0]        disp_o_ready,
    output logic [XLEN-1:0]       disp_o_rs1,
    output logic [XLEN-1:0]       disp_o_rs2,
    output logic                  disp_o_rdwen,
    output logic [RFIDX_W-1:0]    disp_o_rdidx,
    output logic [ITAG_W-1:0]     disp_o_itag,
    input  logic                  lp_wbck_valid,
    input  logic                  lp_wbck_rdwen,
    input  logic [RFIDX_W-1:0]    lp_wbck_rdidx,
    input  logic                  wfi_halt_req,
    output logic                  wfi_halt_ack,
    output logic                  lp_empty,
    output logic [STALLCNT_W-1:0] stall_cnt
);

    disp_state_e state_q, state_d;

    logic                  held_q;
    logic [NCH-1:0]        ch_q;
    logic                  rs1en_q, rs2en_q, rdwen_q, fence_q;
    logic [RFIDX_W-1:0]    rs1idx_q, rs2idx_q, rdidx_q;
    logic [XLEN-1:0]       rs1_q, rs2_q;
    logic [STALLCNT_W-1:0] stall_q;

    logic dep, lp_full, longp, go, fire, load;

    e203_disp_scoreboard #(
        .RFIDX_W  (RFIDX_W),
        .LP_DEPTH (LP_DEPTH),
        .ITAG_W   (ITAG_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .rs1en      (rs1en_q),
        .rs1idx     (rs1idx_q),
        .rs2en      (rs2en_q),
        .rs2idx     (rs2idx_q),
        .rdwen      (rdwen_q),
        .rdidx      (rdidx_q),
        .dep        (dep),
        .alloc      (fire && longp),
        .wbck_valid (lp_wbck_valid),
        .wbck_rdwen (lp_wbck_rdwen),
        .wbck_rdidx (lp_wbck_rdidx),
        .lp_full    (lp_full),
        .lp_empty   (lp_empty),
        .itag       (disp_o_itag)
    );

    assign longp        = |(ch_q & LONGP_MASK);
    assign go           = held_q && !dep && (!fence_q || lp_empty) && (!longp || !lp_full);
    assign disp_o_valid = ch_q & {NCH{go}};
    assign fire         = go && |(ch_q & disp_o_ready);
    // Accepting while the held instruction fires keeps one issue per cycle.
    assign disp_i_ready = (state_q == ST_RUN) && (!held_q || fire);
    assign load         = disp_i_valid && disp_i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= 1'b0;
            stall_q <= '0;
            state_q <= ST_RUN;
        end else begin
            if (load)      held_q <= 1'b1;
            else if (fire) held_q <= 1'b0;
            if (held_q && dep && !(&stall_q)) stall_q <= stall_q + STALLCNT_W'(1);
            state_q <= state_d;
        end
    end

    // NOTE: the payload registers are qualified by held_q, so they carry no
    // reset; a reset only has to clear the valid bit.
    always_ff @(posedge clk) begin
        if (load) begin
            ch_q     <= disp_i_ch;
            rs1en_q  <= disp_i_rs1en;
            rs2en_q  <= disp_i_rs2en;
            rdwen_q  <= disp_i_rdwen;
            rs1idx_q <= disp_i_rs1idx;
            rs2idx_q <= disp_i_rs2idx;
            rdidx_q  <= disp_i_rdidx;
            fence_q  <= disp_i_fence;
            rs1_q    <= (disp_i_rs1idx == '0) ? '0 : disp_i_rs1;
            rs2_q    <= (disp_i_rs2idx == '0) ? '0 : disp_i_rs2;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (wfi_halt_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!wfi_halt_req)              state_d = ST_RUN;
                else if (!held_q && lp_empty)   state_d = ST_HALT;
            end
            ST_HALT:  if (!wfi_halt_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign wfi_halt_ack = (state_q == ST_HALT);
    assign disp_o_rs1   = rs1_q;
    assign disp_o_rs2   = rs2_q;
    assign disp_o_rdwen = rdwen_q;
    assign disp_o_rdidx = rdidx_q;
    assign stall_cnt    = stall_q;

endmodule
